// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf
// Double-buffered frame store. The frame builder writes the back bank while the
// pattern sequencer reads the front bank. A commit/release handshake swaps the
// banks so the reader only ever sees complete frames.
module pingpong_frame_buf #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_commit,
    output logic                  wr_ready,
    output logic                  wr_overflow,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_release,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_frame_valid,
    output logic [7:0]            frame_cnt
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_SHOW,
        ST_PEND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              swap;
    logic              front;
    logic              wr_accept;
    logic [DATA_W-1:0] rd_data_s1;
    logic              rd_valid_s1;

    // Both banks live in one array; the top address bit is the bank select.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    assign wr_ready       = (state != ST_PEND);
    assign rd_frame_valid = (state != ST_EMPTY);
    assign wr_accept      = wr_en && wr_ready;

    // Next-state and swap decision from the commit/release handshake.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (wr_commit) begin
                    state_nxt = ST_SHOW;
                    swap      = 1'b1;
                end
            end
            ST_SHOW: begin
                if (wr_commit && rd_release) begin
                    swap = 1'b1;
                end else if (wr_commit) begin
                    state_nxt = ST_PEND;
                end else if (rd_release) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_PEND: begin
                if (rd_release) begin
                    state_nxt = ST_SHOW;
                    swap      = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // State register, bank pointer and swap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            front     <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (swap) begin
                front     <= ~front;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Rejected writes and commits while the back bank is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_overflow <= 1'b0;
        end else begin
            wr_overflow <= (state == ST_PEND) && (wr_en || wr_commit);
        end
    end

    // Byte-enabled write into the back bank as it stands before any swap.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wr_be[k]) begin
                    mem[{~front, wr_addr}][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // First read stage: sample the front bank; data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_s1 <= 1'b0;
            rd_data_s1  <= '0;
        end else begin
            rd_valid_s1 <= rd_en;
            if (rd_en) begin
                rd_data_s1 <= mem[{front, rd_addr}];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rd_data_s2;
            logic              rd_valid_s2;

            // Optional output register adding one cycle of read latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid_s2 <= 1'b0;
                    rd_data_s2  <= '0;
                end else begin
                    rd_valid_s2 <= rd_valid_s1;
                    if (rd_valid_s1) begin
                        rd_data_s2 <= rd_data_s1;
                    end
                end
            end

            assign rd_data  = rd_data_s2;
            assign rd_valid = rd_valid_s2;
        end else begin : g_no_out_reg
            assign rd_data  = rd_data_s1;
            assign rd_valid = rd_valid_s1;
        end
    endgenerate

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// tb_pingpong_frame_buf
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a frame-count based reference model.
module tb_pingpong_frame_buf;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int OUT_REG = 0;
    localparam int LAT     = 1 + OUT_REG;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_commit;
    logic        wr_ready;
    logic        wr_overflow;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        rd_release;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_frame_valid;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents of both banks, number of committed frames not
    // yet released (0..2), which bank the reader sees, and the read pipeline.
    logic [31:0] model_mem [2][256];
    int          n_frames;
    int          m_front;
    logic [7:0]  m_cnt;
    logic        m_ovf;
    logic        pv [LAT];
    logic [31:0] pd [LAT];
    logic [31:0] m_rd_data;

    pingpong_frame_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OUT_REG(OUT_REG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_be         (wr_be),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_commit     (wr_commit),
        .wr_ready      (wr_ready),
        .wr_overflow   (wr_overflow),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_release    (rd_release),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_frame_valid(rd_frame_valid),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        n_frames  = 0;
        m_front   = 0;
        m_cnt     = 8'd0;
        m_ovf     = 1'b0;
        m_rd_data = 32'd0;
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = 32'd0;
        end
    endtask

    task automatic checkAll();
        checkOutput("wr_ready", {31'd0, wr_ready}, {31'd0, n_frames < 2});
        checkOutput("rd_frame_valid", {31'd0, rd_frame_valid}, {31'd0, n_frames > 0});
        checkOutput("frame_cnt", {24'd0, frame_cnt}, {24'd0, m_cnt});
        checkOutput("wr_overflow", {31'd0, wr_overflow}, {31'd0, m_ovf});
        checkOutput("rd_valid", {31'd0, rd_valid}, {31'd0, pv[LAT-1]});
        checkOutput("rd_data", rd_data, m_rd_data);
    endtask

    // One clock cycle with the currently driven inputs; the model advances
    // from its pre-edge view and all outputs are compared 1 time unit later.
    task automatic step();
        logic        c_acc;
        logic        r_eff;
        logic        w_acc;
        logic        ovf;
        logic [31:0] rdv;
        int          n_next;
        int          back;
        c_acc  = wr_commit && (n_frames < 2);
        r_eff  = rd_release && (n_frames > 0);
        w_acc  = wr_en && (n_frames < 2);
        ovf    = (n_frames == 2) && (wr_en || wr_commit);
        rdv    = model_mem[m_front][rd_addr];
        back   = 1 - m_front;
        @(posedge clk);
        #1;
        if (w_acc) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) model_mem[back][wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            end
        end
        n_next = n_frames + int'(c_acc) - int'(r_eff);
        // The reader moves to a newer frame whenever the count changes and
        // lands on exactly one outstanding frame.
        if ((c_acc || r_eff) && n_next == 1) begin
            m_front = 1 - m_front;
            m_cnt   = m_cnt + 8'd1;
        end
        n_frames = n_next;
        m_ovf    = ovf;
        for (int i = LAT - 1; i > 0; i--) begin
            if (pv[i-1]) pd[i] = pd[i-1];
            pv[i] = pv[i-1];
        end
        pv[0] = rd_en;
        if (rd_en) pd[0] = rdv;
        if (pv[LAT-1]) m_rd_data = pd[LAT-1];
        checkAll();
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [7:0] wa,
                                 input logic [31:0] wd, input logic cm, input logic re,
                                 input logic [7:0] ra, input logic rl);
        wr_en      = we;
        wr_be      = be;
        wr_addr    = wa;
        wr_data    = wd;
        wr_commit  = cm;
        rd_en      = re;
        rd_addr    = ra;
        rd_release = rl;
        step();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_data"}, rd_data, 32'd0);
        checkOutput({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        checkOutput({tag, "_wr_overflow"}, {31'd0, wr_overflow}, 32'd0);
        checkOutput({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
        checkOutput({tag, "_frame_valid"}, {31'd0, rd_frame_valid}, 32'd0);
        checkOutput({tag, "_frame_cnt"}, {24'd0, frame_cnt}, 32'd0);
    endtask

    // Asynchronous reset applied mid-cycle, held across one edge with quiet inputs.
    task automatic doReset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues(tag);
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_be = 4'h0; wr_addr = 8'd0; wr_data = 32'd0; wr_commit = 1'b0;
        rd_en = 1'b0; rd_addr = 8'd0; rd_release = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) model_mem[b][a] = 32'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;

        // Full first frame into bank 1, then commit.
        for (int a = 0; a < 256; a++)
            applyStimulus(1'b1, 4'hF, 8'(a), 32'hA500_0000 + 32'(a), 1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("commit1_frame_valid", {31'd0, rd_frame_valid}, 32'd1);
        checkOutput("commit1_cnt", {24'd0, frame_cnt}, 32'd1);
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd7, 1'b0);
        repeat (LAT - 1) idle();
        checkOutput("read7_valid", {31'd0, rd_valid}, 32'd1);
        checkOutput("read7_data", rd_data, 32'hA500_0007);

        // Second frame into bank 0 with a byte-enable merge at address 5.
        for (int a = 0; a < 256; a++)
            applyStimulus(1'b1, 4'hF, 8'(a), 32'h5A00_0000 + 32'(a), 1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 4'hF, 8'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 4'h5, 8'd5, 32'h1234_5678, 1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("pend_wr_ready", {31'd0, wr_ready}, 32'd0);
        applyStimulus(1'b1, 4'hF, 8'd5, 32'h0000_0000, 1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("pend_write_ovf", {31'd0, wr_overflow}, 32'd1);
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("pend_commit_ovf", {31'd0, wr_overflow}, 32'd1);
        idle();
        checkOutput("ovf_pulse_end", {31'd0, wr_overflow}, 32'd0);
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("release_cnt", {24'd0, frame_cnt}, 32'd2);
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd5, 1'b0);
        repeat (LAT - 1) idle();
        checkOutput("byte_enable_data", rd_data, 32'hFF34_FF78);

        // Simultaneous commit and release with a read in the swap cycle.
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 1'b1, 8'd7, 1'b1);
        checkOutput("simul_cnt", {24'd0, frame_cnt}, 32'd3);
        checkOutput("simul_frame_valid", {31'd0, rd_frame_valid}, 32'd1);
        checkOutput("simul_wr_ready", {31'd0, wr_ready}, 32'd1);
        repeat (LAT - 1) idle();
        checkOutput("simul_old_frame", rd_data, 32'h5A00_0007);
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd7, 1'b0);
        repeat (LAT - 1) idle();
        checkOutput("simul_new_frame", rd_data, 32'hA500_0007);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), $urandom,
                          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                          8'($urandom), ($urandom_range(0, 7) == 0));
        end

        // Counter wrap after 256 swaps, starting from a fresh reset.
        doReset("reset2");
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("empty_release_valid", {31'd0, rd_frame_valid}, 32'd0);
        checkOutput("empty_release_cnt", {24'd0, frame_cnt}, 32'd0);
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 1'b0, 8'd0, 1'b0);
            applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1);
        end
        checkOutput("cnt_255", {24'd0, frame_cnt}, 32'd255);
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("cnt_wrap", {24'd0, frame_cnt}, 32'd0);

        // Reset during a write burst with reads in flight.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 4'hF, 8'(i), $urandom, 1'b0, 1'b1, 8'(i), 1'b0);
        wr_en = 1'b1; rd_en = 1'b1; wr_addr = 8'd9; rd_addr = 8'd9;
        doReset("reset3");
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("post_reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        end
        applyStimulus(1'b0, 4'h0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd3, 1'b0);
        repeat (LAT - 1) idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
